// File: rtl/motor_pwm_hbridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : motor_pwm_hbridge_pkg
//  Brief    : Shared types, direction constants and the command-to-duty
//             helper for the H-bridge PWM stage.
//  Revision : 1.0 - initial release
// ============================================================================
package motor_pwm_hbridge_pkg;

    // Bridge controller states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN_FWD = 2'd1,
        RUN_REV = 2'd2,
        DEAD    = 2'd3
    } state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    // Magnitude of a sign-extended command, clamped to the PWM period.
    // The most negative command maps to its true magnitude (no wrap).
    function automatic logic [31:0] abs_clamp(input logic signed [31:0] value,
                                              input int unsigned         period);
        logic [31:0] w_mag;
        w_mag = value[31] ? 32'(-value) : 32'(value);
        return (w_mag > period) ? period : w_mag;
    endfunction

endpackage
`default_nettype wire

// File: rtl/motor_pwm_hbridge_if.sv
`default_nettype none
// ============================================================================
//  Module   : motor_pwm_hbridge_if
//  Brief    : Command-in / bridge-out bundle of the H-bridge PWM stage.
//             master = command source, slave = bridge driver.
//  Revision : 1.0 - initial release
// ============================================================================
interface motor_pwm_hbridge_if #(
    parameter int DIN_W = 14
);
    logic             en;
    logic [DIN_W-1:0] din;
    logic             pwm_a;
    logic             pwm_b;
    logic             dir;
    logic             period_start;

    modport master (
        output en, din,
        input  pwm_a, pwm_b, dir, period_start
    );

    modport slave (
        input  en, din,
        output pwm_a, pwm_b, dir, period_start
    );
endinterface
`default_nettype wire

// File: rtl/motor_pwm_hbridge_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_tick_gen
//  Brief    : Prescaler and edge-aligned PWM period counter. Flags the last
//             tick of each period (boundary) and pulses period_start on the
//             first clock of the following period.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_tick_gen #(
    parameter int PRESCALE = 1,
    parameter int CNT_W    = 13,
    parameter int PERIOD   = 8192
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_en,
    output logic      [CNT_W-1:0] o_cnt,
    output logic                  o_boundary,
    output logic                  o_period_start
);
    // A prescale of 1 still needs a 1-bit register; it simply stays at 0.
    localparam int               PRE_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] c_pre_last = PRE_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(PERIOD - 1);

    logic [PRE_W-1:0] r_pre;
    logic [CNT_W-1:0] r_cnt;
    logic             r_period_start;
    logic             w_tick;

    assign w_tick     = (r_pre == c_pre_last);
    assign o_boundary = i_en && w_tick && (r_cnt == c_cnt_last);

    // Prescaler, period counter and the start-of-period pulse; disable parks at zero
    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_pre          <= '0;
            r_cnt          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick) begin
                r_cnt <= (r_cnt == c_cnt_last) ? '0 : r_cnt + 1'b1;
            end
            r_period_start <= o_boundary;
        end
    end

    assign o_cnt          = r_cnt;
    assign o_period_start = r_period_start;

endmodule
`default_nettype wire

// File: rtl/motor_pwm_hbridge.sv
`default_nettype none
// ============================================================================
//  Module   : motor_pwm_hbridge
//  Brief    : Signed command to 2-input H-bridge driver. Magnitude sets the
//             duty of an edge-aligned PWM, sign sets the active leg. Duty and
//             direction change only at period boundaries, and every reversal
//             inserts a dead-time gap with both legs low.
//  Revision : 1.0 - initial release
// ============================================================================
module motor_pwm_hbridge
    import motor_pwm_hbridge_pkg::*;
#(
    parameter int DIN_W    = 14,
    parameter int CNT_W    = 13,
    parameter int PERIOD   = 8192,
    parameter int PRESCALE = 1,
    parameter int DEADTIME = 16,
    parameter int CLK_FREQ = -1
) (
    input wire logic            clk,
    input wire logic            rst,
    motor_pwm_hbridge_if.slave  bus
);
    localparam int               DUTY_W      = CNT_W + 1;
    localparam int               DEAD_W      = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam logic [DEAD_W-1:0] c_dead_load = DEAD_W'(DEADTIME - 1);
    // An illegal parameter set parks the bridge with both legs off.
    localparam bit c_params_ok = (PERIOD <= (1 << CNT_W)) && (PERIOD >= 1) &&
                                 (PRESCALE >= 1) && (DEADTIME >= 1) && (CLK_FREQ != 0);

    logic [CNT_W-1:0]  w_cnt;
    logic              w_boundary;
    logic              w_period_start;
    logic              w_dir_new;
    logic [DUTY_W-1:0] w_duty_new;
    logic              w_dir_eff;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DEAD_W-1:0] r_dead_cnt;
    logic [DEAD_W-1:0] w_dead_nxt;
    logic              r_dir;
    logic              w_dir_nxt;
    logic              r_dir_req;
    logic [DUTY_W-1:0] r_duty_sh;
    logic              r_pwm_a;
    logic              r_pwm_b;

    pwm_tick_gen #(
        .PRESCALE (PRESCALE),
        .CNT_W    (CNT_W),
        .PERIOD   (PERIOD)
    ) u_tick_gen (
        .clk            (clk),
        .rst            (rst),
        .i_en           (bus.en),
        .o_cnt          (w_cnt),
        .o_boundary     (w_boundary),
        .o_period_start (w_period_start)
    );

    // Candidate shadow values, only ever captured at a boundary
    assign w_dir_new  = bus.din[DIN_W-1];
    assign w_duty_new = DUTY_W'(abs_clamp(32'(signed'(bus.din)), PERIOD));
    // A boundary landing in the same clock as the dead-time expiry wins
    assign w_dir_eff  = w_boundary ? w_dir_new : r_dir_req;

    // State, dead counter, applied direction and shadow registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_dead_cnt <= '0;
            r_dir      <= DIR_FWD;
            r_dir_req  <= DIR_FWD;
            r_duty_sh  <= '0;
        end else if (!bus.en) begin
            r_state    <= IDLE;
            r_dead_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_dead_cnt <= w_dead_nxt;
            r_dir      <= w_dir_nxt;
            if (w_boundary) begin
                r_dir_req <= w_dir_new;
                r_duty_sh <= w_duty_new;
            end
        end
    end

    // Next-state logic: reversals with non-zero duty go through DEAD
    always_comb begin
        w_state_nxt = r_state;
        w_dead_nxt  = r_dead_cnt;
        w_dir_nxt   = r_dir;
        case (r_state)
            IDLE: begin
                if (w_boundary) begin
                    w_state_nxt = (w_dir_new == DIR_REV) ? RUN_REV : RUN_FWD;
                    w_dir_nxt   = w_dir_new;
                end
            end
            RUN_FWD, RUN_REV: begin
                if (w_boundary && (w_dir_new != r_dir) && (w_duty_new != '0)) begin
                    w_state_nxt = DEAD;
                    w_dead_nxt  = c_dead_load;
                end
            end
            DEAD: begin
                if (r_dead_cnt == '0) begin
                    w_state_nxt = (w_dir_eff == DIR_REV) ? RUN_REV : RUN_FWD;
                    w_dir_nxt   = w_dir_eff;
                end else begin
                    w_dead_nxt = r_dead_cnt - 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Registered bridge legs; only the leg of the running direction may be high
    always_ff @(posedge clk) begin
        if (rst || !bus.en) begin
            r_pwm_a <= 1'b0;
            r_pwm_b <= 1'b0;
        end else begin
            r_pwm_a <= c_params_ok && (r_state == RUN_FWD) && ({1'b0, w_cnt} < r_duty_sh);
            r_pwm_b <= c_params_ok && (r_state == RUN_REV) && ({1'b0, w_cnt} < r_duty_sh);
        end
    end

    assign bus.pwm_a        = r_pwm_a;
    assign bus.pwm_b        = r_pwm_b;
    assign bus.dir          = r_dir;
    assign bus.period_start = w_period_start;

endmodule
`default_nettype wire
